// File: rtl/alu_op_sequencer.sv
// Drives one shared 4-bit ALU slice nibble by nibble, LSB first, to run a wide operation.
// Commands come in and results go out over valid/ready handshakes.
module alu_op_sequencer #(
    parameter int unsigned NIBBLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [3:0]           i_cmd_op,
    input  logic [4*NIBBLES-1:0] i_cmd_a,
    input  logic [4*NIBBLES-1:0] i_cmd_b,
    output logic [3:0]           o_alu_a,
    output logic [3:0]           o_alu_b,
    output logic                 o_alu_inva,
    output logic                 o_alu_ena,
    output logic                 o_alu_enb,
    output logic                 o_alu_f1,
    output logic                 o_alu_f0,
    output logic                 o_alu_cin,
    input  logic [3:0]           i_alu_result,
    input  logic                 i_alu_cout,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [4*NIBBLES-1:0] o_rsp_result,
    output logic                 o_rsp_cout,
    output logic                 o_rsp_zero,
    output logic                 o_busy
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [3:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic [W-1:0]     w_result_next;
    logic             r_carry;
    logic             r_zero;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W+1:0] w_base;
    logic             w_last;
    logic [5:0]       w_ctrl;

    assign w_base = {r_idx, 2'b00};
    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

    // Control word {INVA, ENA, ENB, F1, F0, CIN0}
    always_comb begin
        w_ctrl = 6'b000000;
        case (r_op)
            4'h0: w_ctrl = 6'b010010;
            4'h1: w_ctrl = 6'b001010;
            4'h2: w_ctrl = 6'b110010;
            4'h3: w_ctrl = 6'b001100;
            4'h4: w_ctrl = 6'b011110;
            4'h5: w_ctrl = 6'b011111;
            4'h6: w_ctrl = 6'b010111;
            4'h7: w_ctrl = 6'b001111;
            4'h8: w_ctrl = 6'b111111;
            4'h9: w_ctrl = 6'b101110;
            4'hA: w_ctrl = 6'b110111;
            4'hB: w_ctrl = 6'b011000;
            4'hC: w_ctrl = 6'b011010;
            4'hD: w_ctrl = 6'b000110;
            4'hE: w_ctrl = 6'b000111;
            4'hF: w_ctrl = 6'b100110;
            default: w_ctrl = 6'b000000;
        endcase
    end

    // ALU drive is forced to zero outside EXEC so the slice computes 0 & 0.
    always_comb begin
        o_alu_a    = 4'h0;
        o_alu_b    = 4'h0;
        o_alu_inva = 1'b0;
        o_alu_ena  = 1'b0;
        o_alu_enb  = 1'b0;
        o_alu_f1   = 1'b0;
        o_alu_f0   = 1'b0;
        o_alu_cin  = 1'b0;
        if (r_state == StExec) begin
            o_alu_a    = r_a[w_base +: 4];
            o_alu_b    = r_b[w_base +: 4];
            o_alu_inva = w_ctrl[5];
            o_alu_ena  = w_ctrl[4];
            o_alu_enb  = w_ctrl[3];
            o_alu_f1   = w_ctrl[2];
            o_alu_f0   = w_ctrl[1];
            if (r_idx == '0) begin
                o_alu_cin = w_ctrl[0];
            end else if (w_ctrl[2:1] == 2'b11) begin
                o_alu_cin = r_carry;
            end
        end
    end

    always_comb begin
        w_result_next                = r_result;
        w_result_next[w_base +: 4]   = i_alu_result;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (i_cmd_valid) w_state_next = StExec;
            StExec: if (w_last) w_state_next = StResp;
            StResp: if (i_rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_op     <= 4'h0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_op    <= i_cmd_op;
                        r_a     <= i_cmd_a;
                        r_b     <= i_cmd_b;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_zero  <= 1'b0;
                    end
                end
                StExec: begin
                    r_result <= w_result_next;
                    r_carry  <= i_alu_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_zero <= (w_result_next == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready  = (r_state == StIdle);
    assign o_rsp_valid  = (r_state == StResp);
    assign o_busy       = (r_state != StIdle);
    assign o_rsp_result = r_result;
    assign o_rsp_cout   = r_carry;
    assign o_rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: behavioural 4-bit ALU slice, wide golden model feeding a scoreboard queue.
module tb_alu_op_sequencer;

    localparam int unsigned NIBBLES = 2;
    localparam int unsigned W       = 4 * NIBBLES;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_inva;
    logic         alu_ena;
    logic         alu_enb;
    logic         alu_f1;
    logic         alu_f0;
    logic         alu_cin;
    logic [3:0]   alu_result;
    logic         alu_cout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_cout;
    logic         rsp_zero;
    logic         busy;

    exp_t sb[$];
    int   n_pass;
    int   n_fail;
    int   n_total;

    alu_op_sequencer #(.NIBBLES(NIBBLES)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_a      (cmd_a),
        .i_cmd_b      (cmd_b),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_inva   (alu_inva),
        .o_alu_ena    (alu_ena),
        .o_alu_enb    (alu_enb),
        .o_alu_f1     (alu_f1),
        .o_alu_f0     (alu_f0),
        .o_alu_cin    (alu_cin),
        .i_alu_result (alu_result),
        .i_alu_cout   (alu_cout),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_cout   (rsp_cout),
        .o_rsp_zero   (rsp_zero),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bitalu_4 slice
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [4:0] m_sum;
    always_comb begin
        m_a   = (alu_ena ? alu_a : 4'h0) ^ {4{alu_inva}};
        m_b   = alu_enb ? alu_b : 4'h0;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {4'h0, alu_cin};
        alu_cout = 1'b0;
        case ({alu_f1, alu_f0})
            2'b00: alu_result = m_a & m_b;
            2'b01: alu_result = m_a | m_b;
            2'b10: alu_result = ~m_b;
            default: begin
                alu_result = m_sum[3:0];
                alu_cout   = m_sum[4];
            end
        endcase
    end

    function automatic exp_t golden(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        logic [W:0] s;
        logic [W:0] one;
        exp_t       e;
        one = (W+1)'(1);
        case (op)
            4'h0: s = {1'b0, a};
            4'h1: s = {1'b0, b};
            4'h2: s = {1'b0, ~a};
            4'h3: s = {1'b0, ~b};
            4'h4: s = {1'b0, a} + {1'b0, b};
            4'h5: s = {1'b0, a} + {1'b0, b} + one;
            4'h6: s = {1'b0, a} + one;
            4'h7: s = {1'b0, b} + one;
            4'h8: s = {1'b0, b} + {1'b0, ~a} + one;
            4'h9: s = {1'b0, b} + {1'b0, {W{1'b1}}};
            4'hA: s = {1'b0, ~a} + one;
            4'hB: s = {1'b0, a & b};
            4'hC: s = {1'b0, a | b};
            4'hD: s = '0;
            4'hE: s = one;
            default: s = {1'b0, {W{1'b1}}};
        endcase
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.zero = (s[W-1:0] == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold, input bit early,
                          input bit chk_cin, input bit exp_cin);
        exp_t e;
        int   edges;
        @(negedge clk);
        check({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        rsp_ready = early;
        sb.push_back(golden(op, a, b));
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = W'($urandom);
        cmd_b     = W'($urandom);
        check({tag, " busy exec"}, 32'({busy, cmd_ready}), 32'b10);
        while (!rsp_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 2 && chk_cin) check({tag, " cin nibble1"}, 32'(alu_cin), 32'(exp_cin));
        end
        check({tag, " latency"}, edges, NIBBLES + 1);
        if (rsp_valid) begin
            e = sb.pop_front();
            check({tag, " result"}, 32'(rsp_result), 32'(e.res));
            check({tag, " cout"}, 32'(rsp_cout), 32'(e.cout));
            check({tag, " zero"}, 32'(rsp_zero), 32'(e.zero));
            check({tag, " alu idle drive"},
                  32'({alu_a, alu_b, alu_inva, alu_ena, alu_enb, alu_f1, alu_f0, alu_cin}), 32'd0);
            for (int i = 0; i < hold; i++) begin
                cmd_valid = (i == 1);
                @(posedge clk);
                @(negedge clk);
                check({tag, " hold stable"},
                      32'({rsp_valid, cmd_ready, rsp_cout, rsp_zero, rsp_result}),
                      32'({1'b1, 1'b0, e.cout, e.zero, e.res}));
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, " after handshake"}, 32'({rsp_valid, cmd_ready, busy}), 32'b010);
        end else begin
            rsp_ready = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        n_pass    = 0;
        n_fail    = 0;
        n_total   = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("reset state", 32'({cmd_ready, rsp_valid, rsp_cout, rsp_zero, busy, rsp_result}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
        check("reset alu", 32'({alu_a, alu_b, alu_inva, alu_ena, alu_enb, alu_f1, alu_f0, alu_cin}),
              32'd0);
        rst = 1'b0;

        do_cmd("add",     4'h4, 8'h35, 8'h5A, 0, 1'b0, 1'b1, 1'b0);
        do_cmd("add_wrap", 4'h4, 8'hFF, 8'h01, 0, 1'b0, 1'b1, 1'b1);
        do_cmd("b_sub_a", 4'h8, 8'h03, 8'h05, 0, 1'b0, 1'b1, 1'b1);
        do_cmd("neg_a",   4'hA, 8'h0A, 8'h00, 0, 1'b0, 1'b1, 1'b0);
        do_cmd("b_dec",   4'h9, 8'h00, 8'h05, 0, 1'b0, 1'b1, 1'b1);
        do_cmd("one",     4'hE, 8'h77, 8'h88, 0, 1'b0, 1'b1, 1'b0);
        do_cmd("minus1",  4'hF, 8'h12, 8'h34, 0, 1'b1, 1'b1, 1'b0);
        do_cmd("and",     4'hB, 8'hA5, 8'h3C, 0, 1'b0, 1'b1, 1'b0);
        do_cmd("or",      4'hC, 8'hA5, 8'h3C, 5, 1'b0, 1'b1, 1'b0);
        do_cmd("not_a",   4'h2, 8'h5C, 8'h00, 0, 1'b1, 1'b0, 1'b0);
        do_cmd("not_b",   4'h3, 8'h00, 8'hC3, 0, 1'b0, 1'b0, 1'b0);
        do_cmd("add_c1",  4'h5, 8'h7F, 8'h80, 0, 1'b0, 1'b1, 1'b1);
        do_cmd("a_inc",   4'h6, 8'h0F, 8'h00, 0, 1'b0, 1'b1, 1'b1);
        do_cmd("pass_b",  4'h1, 8'h11, 8'h9E, 0, 1'b0, 1'b0, 1'b0);
        do_cmd("zero",    4'hD, 8'hFF, 8'hFF, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of EXEC, on nibble 1
        @(negedge clk);
        cmd_op    = 4'h4;
        cmd_a     = 8'h35;
        cmd_b     = 8'h5A;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("exec nibble1 a", 32'(alu_a), 32'h3);
        rst = 1'b1;
        #1;
        check("midexec reset state",
              32'({cmd_ready, rsp_valid, rsp_cout, rsp_zero, busy, rsp_result}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
        check("midexec reset alu",
              32'({alu_a, alu_b, alu_inva, alu_ena, alu_enb, alu_f1, alu_f0, alu_cin}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("no response after reset", 32'({rsp_valid, busy}), 32'd0);
        do_cmd("post_reset", 4'h7, 8'h00, 8'hFF, 0, 1'b0, 1'b1, 1'b1);

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
